// File: rtl/case5_sweep_ctrl.sv
// Sweeps a 6-bit stimulus range into the case5 logic and
// accumulates per-output hit counts plus a 16-bit MISR signature.
module case5_sweep_ctrl #(
  parameter int unsigned SETTLE = 1,
  parameter logic [15:0] SEED   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [5:0]  vec_lo,
  input  logic [5:0]  vec_hi,
  output logic [5:0]  drv,
  input  logic [2:0]  resp,
  output logic        busy,
  output logic        done,
  output logic [6:0]  cnt_x,
  output logic [6:0]  cnt_y,
  output logic [6:0]  cnt_z,
  output logic [15:0] sig
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CAPT,
    S_FIN
  } state_e;

  localparam logic [3:0]  SETTLE_V = 4'(SETTLE);
  localparam logic [15:0] POLY     = 16'h1021;

  state_e      state_q, state_d;
  logic [5:0]  drv_q, drv_d;
  logic [5:0]  hi_q, hi_d;
  logic [3:0]  settle_q, settle_d;
  logic [6:0]  cnt_x_q, cnt_x_d;
  logic [6:0]  cnt_y_q, cnt_y_d;
  logic [6:0]  cnt_z_q, cnt_z_d;
  logic [15:0] sig_q, sig_d;

  logic st_idle;
  logic st_wait;
  logic st_capt;
  logic accept;
  logic wait_dec;
  logic capt;
  logic last_vec;
  logic advance;
  logic [15:0] sig_mix;

  assign st_idle  = (state_q == S_IDLE);
  assign st_wait  = (state_q == S_WAIT);
  assign st_capt  = (state_q == S_CAPT);
  assign accept   = st_idle & start & ~abort;
  assign wait_dec = st_wait & ~abort
                  & (settle_q != 4'd0);
  assign capt     = st_capt & ~abort;
  assign last_vec = (drv_q == hi_q);
  assign advance  = capt & ~last_vec;

  assign sig_mix = {sig_q[14:0], 1'b0}
                 ^ (sig_q[15] ? POLY : 16'h0000)
                 ^ {13'b0, resp};

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (settle_q == 4'd0) begin
          state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (last_vec) begin
          state_d = S_FIN;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // outputs; an abort during FIN suppresses the pulse
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_FIN) & ~abort;
  end

  always_comb begin
    drv_d    = drv_q;
    hi_d     = hi_q;
    settle_d = settle_q;
    unique case (1'b1)
      accept: begin
        drv_d    = vec_lo;
        hi_d     = vec_hi;
        settle_d = SETTLE_V;
      end
      wait_dec: begin
        settle_d = settle_q - 4'd1;
      end
      advance: begin
        drv_d    = drv_q + 6'd1;
        settle_d = SETTLE_V;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    cnt_x_d = cnt_x_q;
    cnt_y_d = cnt_y_q;
    cnt_z_d = cnt_z_q;
    sig_d   = sig_q;
    unique case (1'b1)
      accept: begin
        cnt_x_d = 7'd0;
        cnt_y_d = 7'd0;
        cnt_z_d = 7'd0;
        sig_d   = SEED;
      end
      capt: begin
        cnt_x_d = cnt_x_q + {6'b0, resp[2]};
        cnt_y_d = cnt_y_q + {6'b0, resp[1]};
        cnt_z_d = cnt_z_q + {6'b0, resp[0]};
        sig_d   = sig_mix;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv_q    <= 6'd0;
      hi_q     <= 6'd0;
      settle_q <= 4'd0;
      cnt_x_q  <= 7'd0;
      cnt_y_q  <= 7'd0;
      cnt_z_q  <= 7'd0;
      sig_q    <= SEED;
    end else begin
      drv_q    <= drv_d;
      hi_q     <= hi_d;
      settle_q <= settle_d;
      cnt_x_q  <= cnt_x_d;
      cnt_y_q  <= cnt_y_d;
      cnt_z_q  <= cnt_z_d;
      sig_q    <= sig_d;
    end
  end

  assign drv   = drv_q;
  assign cnt_x = cnt_x_q;
  assign cnt_y = cnt_y_q;
  assign cnt_z = cnt_z_q;
  assign sig   = sig_q;

endmodule

// File: tb/tb_case5_sweep_ctrl.sv
// Bench for case5_sweep_ctrl: a case5 model on resp, a
// scoreboard of sweep results, and directed control checks.
module tb_case5_sweep_ctrl;

  localparam int SETTLE = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [5:0]  vec_lo;
  logic [5:0]  vec_hi;
  logic [5:0]  drv;
  logic [2:0]  resp;
  logic        busy;
  logic        done;
  logic [6:0]  cnt_x;
  logic [6:0]  cnt_y;
  logic [6:0]  cnt_z;
  logic [15:0] sig;

  case5_sweep_ctrl #(
    .SETTLE (SETTLE),
    .SEED   (16'hFFFF)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .vec_lo (vec_lo),
    .vec_hi (vec_hi),
    .drv    (drv),
    .resp   (resp),
    .busy   (busy),
    .done   (done),
    .cnt_x  (cnt_x),
    .cnt_y  (cnt_y),
    .cnt_z  (cnt_z),
    .sig    (sig)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [6:0]  cx;
    logic [6:0]  cy;
    logic [6:0]  cz;
    logic [15:0] sig;
    logic [5:0]  drv;
    int          at;
  } exp_t;

  exp_t sbq[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] case5(input logic [5:0] v);
    logic a, b, c, d, e, f, x, y, z;
    {a, b, c, d, e, f} = v;
    x = a | (d & (~b | ~c));
    y = b & d & (~c | (a & f & ~e));
    z = (c | d) & (~c | ~d | (b & (e | ~a | ~f)));
    return {x, y, z};
  endfunction

  assign resp = case5(drv);

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, req);
  endfunction

  // golden sweep result; at holds latency relative to start cycle
  function automatic exp_t model(string nm,
                                 logic [5:0] lo,
                                 logic [5:0] hi);
    exp_t e;
    logic [5:0]  v;
    logic [5:0]  diff;
    logic [2:0]  r;
    int          n;
    e.name = nm;
    e.cx = 0; e.cy = 0; e.cz = 0;
    e.sig = 16'hFFFF;
    diff = hi - lo;
    n = int'(diff) + 1;
    v = lo;
    for (int i = 0; i < n; i++) begin
      r = case5(v);
      e.cx = e.cx + {6'b0, r[2]};
      e.cy = e.cy + {6'b0, r[1]};
      e.cz = e.cz + {6'b0, r[0]};
      e.sig = {e.sig[14:0], 1'b0}
            ^ (e.sig[15] ? 16'h1021 : 16'h0000)
            ^ {13'b0, r};
      v = v + 6'd1;
    end
    e.drv = hi;
    e.at  = n * (SETTLE + 2) + 1;
    return e;
  endfunction

  function automatic exp_t hand(string nm, logic [5:0] v,
                                logic [6:0] cx, logic [6:0] cy,
                                logic [6:0] cz, logic [15:0] s,
                                int lat);
    exp_t e;
    e.name = nm;
    e.cx = cx; e.cy = cy; e.cz = cz;
    e.sig = s;
    e.drv = v;
    e.at  = lat;
    return e;
  endfunction

  // monitor: every done pulse consumes one expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sbq.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got done=1 at cyc %0d want none",
                 cyc);
      end else begin
        e = sbq.pop_front();
        chk({e.name, "_lat"}, cyc, e.at);
        chk({e.name, "_cx"}, cnt_x, e.cx);
        chk({e.name, "_cy"}, cnt_y, e.cy);
        chk({e.name, "_cz"}, cnt_z, e.cz);
        chk({e.name, "_sig"}, sig, e.sig);
        chk({e.name, "_drv"}, drv, e.drv);
      end
    end
  end

  task automatic issue(input logic [5:0] lo,
                       input logic [5:0] hi,
                       input exp_t e,
                       input bit push);
    @(negedge clk);
    vec_lo = lo;
    vec_hi = hi;
    start  = 1'b1;
    e.at   = e.at + cyc;
    if (push) sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(string nm, int limit);
    int t = 0;
    while (done !== 1'b1 && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (done !== 1'b1) begin
      n_total++;
      $display("FAIL %s_timeout: got no done want done", nm);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    vec_lo = 6'd0;
    vec_hi = 6'd0;
    repeat (2) @(negedge clk);
    chk("rst_drv", drv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", {cnt_x, cnt_y, cnt_z}, 0);
    chk("rst_sig", sig, 16'hFFFF);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_auto_start", busy, 0);

    issue(6'd0, 6'd0,
          hand("v000", 6'd0, 0, 0, 0, 16'hEFDF, 4), 1);
    wait_done("v000", 20);
    issue(6'b010100, 6'b010100,
          hand("v024", 6'b010100, 1, 1, 1, 16'hEFD8, 4), 1);
    wait_done("v024", 20);
    issue(6'b100000, 6'b100000,
          hand("v040", 6'b100000, 1, 0, 0, 16'hEFDB, 4), 1);
    wait_done("v040", 20);
    issue(6'd0, 6'd63, model("full", 6'd0, 6'd63), 1);
    wait_done("full", 300);
    issue(6'd62, 6'd1, model("wrap", 6'd62, 6'd1), 1);
    wait_done("wrap", 30);
    chk("wrap_lat_hand", model("w", 6'd62, 6'd1).at, 13);

    // abort in the second WAIT of a 64-vector sweep
    issue(6'd20, 6'd19, model("ab", 6'd20, 6'd19), 0);
    repeat (3) @(negedge clk);
    chk("ab_busy_pre", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_cnt", {cnt_x, cnt_y, cnt_z}, {7'd1, 7'd1, 7'd1});
    chk("ab_sig", sig, 16'hEFD8);
    chk("ab_drv", drv, 21);
    repeat (5) @(negedge clk);
    chk("ab_idle", busy, 0);

    // reset pulsed during the second CAPT
    issue(6'd8, 6'd11, model("rs", 6'd8, 6'd11), 0);
    repeat (5) @(negedge clk);
    chk("rs_busy_pre", busy, 1);
    chk("rs_cz_pre", cnt_z, 1);
    rst_n = 1'b0;
    #1;
    chk("rs_drv", drv, 0);
    chk("rs_busy", busy, 0);
    chk("rs_done", done, 0);
    chk("rs_cnt", {cnt_x, cnt_y, cnt_z}, 0);
    chk("rs_sig", sig, 16'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rs_no_start", busy, 0);

    // start held through the sweep and FIN
    @(negedge clk);
    vec_lo = 6'd5;
    vec_hi = 6'd7;
    start  = 1'b1;
    begin
      exp_t e;
      e = model("hold", 6'd5, 6'd7);
      e.at = e.at + cyc;
      sbq.push_back(e);
    end
    begin
      int t = 0;
      @(negedge clk);
      while (done !== 1'b1 && t < 40) begin
        @(negedge clk);
        t++;
      end
      if (done !== 1'b1) begin
        n_total++;
        $display("FAIL hold_timeout: got no done want done");
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("hold_fin_idle", busy, 0);
    repeat (4) @(negedge clk);
    chk("hold_no_queue", busy, 0);

    chk("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
